// File: rtl/clock_cache.sv
// Fully associative K-way cache with CLOCK (second-chance) replacement.
// Define CLOCK_CACHE_EVICT_OUT_EN to expose evict_valid/evict_addr/evict_val for victims.
module clock_cache #(
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = 32,
  parameter int K          = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [LINE_WIDTH-1:0] in_val,
  input  logic                  read,
  input  logic                  write,
  output logic                  ready,
  output logic                  done,
  output logic                  hit,
  output logic [LINE_WIDTH-1:0] out_val
`ifdef CLOCK_CACHE_EVICT_OUT_EN
  ,
  output logic                  evict_valid,
  output logic [ADDR_WIDTH-1:0] evict_addr,
  output logic [LINE_WIDTH-1:0] evict_val
`endif
);

  localparam int PW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [K-1:0]          r_valid;
  logic [K-1:0]          r_ref;
  logic [ADDR_WIDTH-1:0] r_addr [K];
  logic [LINE_WIDTH-1:0] r_val  [K];
  logic [PW-1:0]         r_ptr;
  logic [ADDR_WIDTH-1:0] r_pendAddr;
  logic [LINE_WIDTH-1:0] r_pendVal;
  logic                  r_done;
  logic                  r_hit;
  logic [LINE_WIDTH-1:0] r_outVal;

  logic                  w_hitAny;
  logic [PW-1:0]         w_hitIdx;
  logic                  w_freeAny;
  logic [PW-1:0]         w_freeIdx;
  logic [PW-1:0]         w_ptrNext;
  logic                  w_doWrite;
  logic                  w_doRead;
  logic                  w_startSweep;
  logic                  w_ptrRef;

  // Scanning downwards leaves the lowest matching / lowest invalid index.
  always_comb begin
    w_hitAny  = 1'b0;
    w_hitIdx  = '0;
    w_freeAny = 1'b0;
    w_freeIdx = '0;
    for (int i = K - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_addr[i] == in_addr)) begin
        w_hitAny = 1'b1;
        w_hitIdx = PW'(i);
      end
      if (!r_valid[i]) begin
        w_freeAny = 1'b1;
        w_freeIdx = PW'(i);
      end
    end
  end

  assign w_ptrNext    = (r_ptr == PW'(K - 1)) ? '0 : r_ptr + 1'b1;
  assign w_doWrite    = (r_state == IDLE) && write;
  assign w_doRead     = (r_state == IDLE) && read && !write;
  assign w_startSweep = w_doWrite && !w_hitAny && !w_freeAny;
  assign w_ptrRef     = r_ref[r_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_startSweep) w_nextState = SWEEP;
      SWEEP:   if (!w_ptrRef)    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid    <= '0;
      r_ref      <= '0;
      r_ptr      <= '0;
      r_pendAddr <= '0;
      r_pendVal  <= '0;
      r_done     <= 1'b0;
      r_hit      <= 1'b0;
      r_outVal   <= '0;
      for (int i = 0; i < K; i++) begin
        r_addr[i] <= '0;
        r_val[i]  <= '0;
      end
    end else begin
      r_done <= 1'b0;
      if (w_doWrite) begin
        if (w_hitAny) begin
          r_val[w_hitIdx] <= in_val;
          r_ref[w_hitIdx] <= 1'b1;
          r_done          <= 1'b1;
          r_hit           <= 1'b1;
        end else if (w_freeAny) begin
          r_valid[w_freeIdx] <= 1'b1;
          r_ref[w_freeIdx]   <= 1'b1;
          r_addr[w_freeIdx]  <= in_addr;
          r_val[w_freeIdx]   <= in_val;
          r_done             <= 1'b1;
          r_hit              <= 1'b0;
        end else begin
          r_pendAddr <= in_addr;
          r_pendVal  <= in_val;
        end
      end else if (w_doRead) begin
        r_done <= 1'b1;
        r_hit  <= w_hitAny;
        if (w_hitAny) begin
          r_outVal        <= r_val[w_hitIdx];
          r_ref[w_hitIdx] <= 1'b1;
        end
      end else if (r_state == SWEEP) begin
        // Second chance: a referenced way loses its bit, an unreferenced one is the victim.
        if (w_ptrRef) begin
          r_ref[r_ptr] <= 1'b0;
        end else begin
          r_addr[r_ptr] <= r_pendAddr;
          r_val[r_ptr]  <= r_pendVal;
          r_ref[r_ptr]  <= 1'b1;
          r_done        <= 1'b1;
          r_hit         <= 1'b0;
        end
        r_ptr <= w_ptrNext;
      end
    end
  end

`ifdef CLOCK_CACHE_EVICT_OUT_EN
  logic                  r_evictValid;
  logic [ADDR_WIDTH-1:0] r_evictAddr;
  logic [LINE_WIDTH-1:0] r_evictVal;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_evictValid <= 1'b0;
      r_evictAddr  <= '0;
      r_evictVal   <= '0;
    end else begin
      r_evictValid <= 1'b0;
      if ((r_state == SWEEP) && !w_ptrRef) begin
        r_evictValid <= 1'b1;
        r_evictAddr  <= r_addr[r_ptr];
        r_evictVal   <= r_val[r_ptr];
      end
    end
  end

  assign evict_valid = r_evictValid;
  assign evict_addr  = r_evictAddr;
  assign evict_val   = r_evictVal;
`endif

  assign ready   = (r_state == IDLE);
  assign done    = r_done;
  assign hit     = r_hit;
  assign out_val = r_outVal;

endmodule

// File: doc/clock_cache.md
CLOCK_CACHE -- requirements
Module: clock_cache

Interface
REQ-001 Parameter ADDR_WIDTH SHALL default to 8 and set the address width.
REQ-002 Parameter LINE_WIDTH SHALL default to 32 and set the data-line width.
REQ-003 Parameter K SHALL default to 4 and set the number of ways; the legal range is K >= 2, any value, not only a power of two.
REQ-004 Port clock SHALL be an input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 Port reset SHALL be an input, 1 bit, asynchronous and active-high.
REQ-006 Port in_addr SHALL be an input, ADDR_WIDTH bits, the request address.
REQ-007 Port in_val SHALL be an input, LINE_WIDTH bits, the write data.
REQ-008 Port read SHALL be an input, 1 bit, a lookup request.
REQ-009 Port write SHALL be an input, 1 bit, a store request.
REQ-010 Port ready SHALL be an output, 1 bit, high when a new request is accepted.
REQ-011 Port done SHALL be an output, 1 bit, a one-cycle pulse marking request completion.
REQ-012 Port hit SHALL be an output, 1 bit, the result of the request completed with done.
REQ-013 Port out_val SHALL be an output, LINE_WIDTH bits, the read data.

Function
REQ-014 The block SHALL be a fully associative K-way store; each way holds valid, ref, addr and val fields.
REQ-015 The FSM SHALL have two states: IDLE (ready=1) and SWEEP (ready=0).
REQ-016 A request SHALL be accepted only in IDLE; read or write while ready=0 SHALL be ignored.
REQ-017 Read and write high together SHALL be treated as a write only.
REQ-018 Read in IDLE: next edge done=1 and hit=1 if a valid way matches in_addr; on a hit, out_val=val and that way's ref=1.
REQ-019 On a read miss, hit=0 and out_val SHALL hold its previous value.
REQ-020 Write hit in IDLE: next edge, val=in_val, ref=1, done=1, hit=1 (one-cycle latency).
REQ-021 Write miss with any invalid way: next edge, fill the lowest-index invalid way (valid=1, ref=1), done=1, hit=0; the CLOCK pointer is unchanged.
REQ-022 Write miss with all ways valid: latch in_addr/in_val and enter SWEEP; inputs are ignored afterwards.
REQ-023 SWEEP, each cycle, way[ptr].ref=1: clear ref and set ptr=ptr+1, wrapping from K-1 to 0.
REQ-024 SWEEP, way[ptr].ref=0: replace it with the latched addr/val (ref=1), set ptr=ptr+1 (wrap), pulse done with hit=0, and return to IDLE.
REQ-025 Worst-case write-miss latency SHALL be K+1 cycles from acceptance to done.
REQ-026 Multiple valid ways SHALL never hold equal addresses.
REQ-027 Outputs hit and done SHALL be registered; done is high for exactly one cycle per accepted request.

Reset
REQ-028 Reset SHALL clear all valid and ref bits, ptr=0, state=IDLE, done=0, hit=0 and out_val=0.
REQ-029 Reset asserted mid-SWEEP SHALL abort the write with no done pulse; the latched request is discarded.
REQ-030 After reset deasserts, ready=1 SHALL hold from the first edge.

Configuration
REQ-031 Macro CLOCK_CACHE_EVICT_OUT_EN, when defined, SHALL add three outputs: evict_valid (1 bit), evict_addr (ADDR_WIDTH bits) and evict_val (LINE_WIDTH bits).
REQ-032 When that macro is defined, evict_valid SHALL pulse with done on REQ-024 replacements, carrying the victim's addr/val; it is 0 otherwise, and 0 on reset.
REQ-033 When that macro is undefined, the three ports SHALL be absent and the behaviour otherwise identical.

Verification
REQ-034 Reset, then read 0x10 -> done=1, hit=0, out_val=0.
REQ-035 Write 0x10=0xAAAA0001, then read 0x10 -> write done after 1 cycle with hit=0; read gives hit=1, out_val=0xAAAA0001.
REQ-036 K=4: fill 0x01..0x04, then write 0x05 -> SWEEP clears all refs, wraps, and replaces way0 (0x01) at done 5 cycles later; evict_addr=0x01 if the macro is enabled.
REQ-037 After REQ-036, read 0x02, then write 0x06 -> way1 is skipped (ref cleared) and way2 (0x03) is evicted.
REQ-038 Assert read and write together with addr 0x20 -> handled as a write; a subsequent read of 0x20 hits.
REQ-039 Assert reset 2 cycles into a SWEEP -> no done pulse; all lookups miss; ready=1 after release.
